// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the iteration-counter width helper.
package restoring_divider_pkg;

    // FSM state encoding, fixed so external checkers can decode fsm_state
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The counter must hold the value WIDTH itself
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_addsub_nbit.sv
// Parameterized N-bit adder-subtractor.
// m=0: sum = a + b ; m=1: sum = a - b (two's complement, b inverted plus m as carry-in).
module addsub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         m,
    output logic [N-1:0] sum
);

    logic [N-1:0] b_eff;

    // Conditional inversion of b plus carry-in m gives add or subtract
    always_comb begin
        b_eff = b ^ {N{m}};
        sum   = a + b_eff + {{(N-1){1'b0}}, m};
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: start is sampled on a rising clock edge while idle or done;
// operands are captured on that edge. busy is high for the WIDTH iteration
// cycles, done pulses for exactly one cycle with quotient/remainder valid,
// and the results hold until the next completion. start during busy is
// ignored.
// Optional feature macro: DIV_ZERO_DETECT_EN adds the div_zero port and
// a one-edge early completion for a zero divisor.
// fsm_state exposes the FSM state register for debug and checkers.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
`ifdef DIV_ZERO_DETECT_EN
    output logic             div_zero,
`endif
    output logic [1:0]       fsm_state
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   acc;        // partial remainder A, one extra bit for the borrow
    logic [WIDTH-1:0] q_reg;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] m_reg;      // captured divisor
    logic [CW-1:0]    count;

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   diff;
    logic             restore;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;
    logic             capture;
    logic             zero_path;

    // Iteration ALU, permanently in subtract mode: diff = a_shift - M
    addsub_nbit #(.N(WIDTH + 1)) u_alu (
        .a   (a_shift),
        .b   ({1'b0, m_reg}),
        .m   (1'b1),
        .sum (diff)
    );

    // One restoring step: shift {A,Q} left, keep the difference unless it went negative
    always_comb begin
        shifted   = {acc, q_reg} << 1;
        a_shift   = shifted[2*WIDTH:WIDTH];
        q_shift   = shifted[WIDTH-1:0];
        restore   = diff[WIDTH];
        acc_next  = restore ? a_shift : diff;
        q_next    = {q_shift[WIDTH-1:1], ~restore};
        last_iter = (count == CW'(1));
        capture   = start && (state == ST_IDLE || state == ST_DONE);
`ifdef DIV_ZERO_DETECT_EN
        zero_path = capture && (divisor == '0);
`else
        zero_path = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (capture) state_next = zero_path ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_iter) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (capture) state_next = zero_path ? ST_DONE : ST_RUN;
                else         state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: operand capture, iteration and result write-back
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            acc       <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero  <= 1'b0;
`endif
        end else begin
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
            if (capture) begin
                acc   <= '0;
                q_reg <= dividend;
                m_reg <= divisor;
                count <= CW'(WIDTH);
                if (zero_path) begin
                    quotient  <= '1;
                    remainder <= dividend;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero  <= 1'b1;
`endif
                end
            end else if (state == ST_RUN) begin
                acc   <= acc_next;
                q_reg <= q_next;
                count <= count - CW'(1);
                if (last_iter) begin
                    quotient  <= q_next;
                    remainder <= acc_next[WIDTH-1:0];
                end
            end
        end
    end

    // Status outputs decode the state register only
    always_comb begin
        busy      = (state == ST_RUN);
        done      = (state == ST_DONE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4). Expected results come
// from plain integer division; expected latencies from the documented timing.
// Works with or without DIV_ZERO_DETECT_EN defined.
module tb_restoring_divider;

    localparam int W       = 4;
    localparam int MAX_WAIT = 60;

    logic         clock;
    logic         reset_b;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic [1:0]   fsm_state;
`ifdef DIV_ZERO_DETECT_EN
    logic         div_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
`ifdef DIV_ZERO_DETECT_EN
        .div_zero  (div_zero),
`endif
        .fsm_state (fsm_state)
    );

    // clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_q(input int a, input int b);
        if (b == 0) return '1;
        return W'(a / b);
    endfunction

    function automatic logic [W-1:0] model_r(input int a, input int b);
        if (b == 0) return W'(a);
        return W'(a % b);
    endfunction

    // edges after the capture edge until done is seen
    function automatic int model_latency(input int b);
`ifdef DIV_ZERO_DETECT_EN
        if (b == 0) return 0;
`endif
        return W;
    endfunction

    // ---------------- driver tasks ----------------
    // Present operands with start, return #1 after the capture edge
    task automatic start_op(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clock); #1;
        start    = 1'b0;
    endtask

    // Count edges until done; returns -1 if the bound expires
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < MAX_WAIT) begin
            @(posedge clock); #1;
            edges++;
        end
        if (!done) edges = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_b  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        n_tests++; if (quotient !== '0)  begin n_fail++; $display("FAIL reset_q got %0d want 0", quotient); end
        n_tests++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_r got %0d want 0", remainder); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (fsm_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", fsm_state); end
`ifdef DIV_ZERO_DETECT_EN
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", div_zero); end
`endif
        reset_b = 1'b1;
        @(posedge clock); #1;
    endtask

    // 13/3 with cycle-level timing and result hold checks
    task automatic test_basic_timing;
        int e;
        start_op(13, 3);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_capture got %b want 1", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_after_capture got %b want 0", done); end
        @(posedge clock); #1;
        n_tests++; if (quotient !== '0) begin n_fail++; $display("FAIL basic_q_hold_in_run got %0d want 0", quotient); end
        wait_done(e);
        n_tests++; if (e + 1 !== W) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", e + 1, W); end
        n_tests++; if (quotient !== 4'd4)  begin n_fail++; $display("FAIL basic_q got %0d want 4", quotient); end
        n_tests++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL basic_r got %0d want 1", remainder); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        @(posedge clock); #1;
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_tests++; if (quotient !== 4'd4)  begin n_fail++; $display("FAIL basic_q_held got %0d want 4", quotient); end
    endtask

    // Boundary operands, including divide by zero
    task automatic test_boundary;
        int ta[5] = '{15, 2, 15, 9, 0};
        int tb[5] = '{1, 5, 15, 0, 7};
        int e;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(e);
            n_tests++; if (e !== model_latency(tb[i])) begin n_fail++; $display("FAIL bnd_latency %0d/%0d got %0d want %0d", ta[i], tb[i], e, model_latency(tb[i])); end
            n_tests++; if (quotient !== model_q(ta[i], tb[i])) begin n_fail++; $display("FAIL bnd_q %0d/%0d got %0d want %0d", ta[i], tb[i], quotient, model_q(ta[i], tb[i])); end
            n_tests++; if (remainder !== model_r(ta[i], tb[i])) begin n_fail++; $display("FAIL bnd_r %0d/%0d got %0d want %0d", ta[i], tb[i], remainder, model_r(ta[i], tb[i])); end
`ifdef DIV_ZERO_DETECT_EN
            n_tests++; if (div_zero !== (tb[i] == 0)) begin n_fail++; $display("FAIL bnd_dz %0d/%0d got %b want %b", ta[i], tb[i], div_zero, tb[i] == 0); end
`endif
            @(posedge clock); #1;
`ifdef DIV_ZERO_DETECT_EN
            n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL bnd_dz_clear got %b want 0", div_zero); end
`endif
        end
    endtask

    // start during RUN with new operands must be ignored
    task automatic test_ignore_start;
        int e;
        start_op(13, 3);
        @(posedge clock); #1;
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd2;
        @(posedge clock); #1;
        start    = 1'b0;
        wait_done(e);
        n_tests++; if (e !== W - 2) begin n_fail++; $display("FAIL ign_latency got %0d want %0d", e, W - 2); end
        n_tests++; if (quotient !== 4'd4)  begin n_fail++; $display("FAIL ign_q got %0d want 4", quotient); end
        n_tests++; if (remainder !== 4'd1) begin n_fail++; $display("FAIL ign_r got %0d want 1", remainder); end
        @(posedge clock); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_restart got %b want 0", busy); end
    endtask

    // start held high through DONE: second op accepted at the DONE edge
    task automatic test_back_to_back;
        int e1, e2;
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(posedge clock); #1;
        dividend = 4'd11;
        divisor  = 4'd2;
        wait_done(e1);
        n_tests++; if (e1 !== W) begin n_fail++; $display("FAIL b2b_lat1 got %0d want %0d", e1, W); end
        n_tests++; if (quotient !== 4'd3 || remainder !== 4'd2) begin n_fail++; $display("FAIL b2b_res1 got q=%0d r=%0d want q=3 r=2", quotient, remainder); end
        @(posedge clock); #1;
        start = 1'b0;
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got busy=%b done=%b want busy=1 done=0", busy, done); end
        n_tests++; if (quotient !== 4'd3) begin n_fail++; $display("FAIL b2b_q_hold got %0d want 3", quotient); end
        wait_done(e2);
        n_tests++; if (e2 + 1 !== W + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", e2 + 1, W + 1); end
        n_tests++; if (quotient !== 4'd5 || remainder !== 4'd1) begin n_fail++; $display("FAIL b2b_res2 got q=%0d r=%0d want q=5 r=1", quotient, remainder); end
        @(posedge clock); #1;
    endtask

    // Asynchronous reset during the second RUN cycle aborts immediately
    task automatic test_reset_mid;
        int e;
        start_op(13, 3);
        @(posedge clock); #1;
        #2 reset_b = 1'b0;
        #1;
        n_tests++; if (quotient !== '0 || remainder !== '0) begin n_fail++; $display("FAIL rst_mid_results got q=%0d r=%0d want 0 0", quotient, remainder); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags got busy=%b done=%b want 0 0", busy, done); end
        n_tests++; if (fsm_state !== 2'b00) begin n_fail++; $display("FAIL rst_mid_state got %b want 00", fsm_state); end
        @(posedge clock); #1;
        reset_b = 1'b1;
        @(posedge clock); #1;
        n_tests++; if (busy !== 1'b0 || quotient !== '0) begin n_fail++; $display("FAIL rst_mid_stay_idle got busy=%b q=%0d want 0 0", busy, quotient); end
        start_op(12, 5);
        wait_done(e);
        n_tests++; if (e !== W) begin n_fail++; $display("FAIL rst_mid_latency got %0d want %0d", e, W); end
        n_tests++; if (quotient !== 4'd2 || remainder !== 4'd2) begin n_fail++; $display("FAIL rst_mid_12_5 got q=%0d r=%0d want q=2 r=2", quotient, remainder); end
        @(posedge clock); #1;
    endtask

    // Random operands against the integer model, via a scoreboard queue
    task automatic test_random;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_r[$];
        int exp_lat[$];
        int a, b, e;
        logic [W-1:0] wq, wr;
        int wl;
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, (1 << W) - 1);
            b = $urandom_range(0, (1 << W) - 1);
            exp_q.push_back(model_q(a, b));
            exp_r.push_back(model_r(a, b));
            exp_lat.push_back(model_latency(b));
            start_op(a, b);
            wait_done(e);
            wq = exp_q.pop_front();
            wr = exp_r.pop_front();
            wl = exp_lat.pop_front();
            n_tests++; if (e !== wl) begin n_fail++; $display("FAIL rnd_latency %0d/%0d got %0d want %0d", a, b, e, wl); end
            n_tests++; if (quotient !== wq || remainder !== wr) begin n_fail++; $display("FAIL rnd_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", a, b, quotient, remainder, wq, wr); end
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_timing();
        test_boundary();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
